// File: rtl/overlay_frame_scheduler.sv
// rtl/overlay_frame_scheduler.sv - frame-synchronous layer/background config scheduler
// Optional shadow readback port cfgRdata is enabled by defining OVERLAY_CFG_READBACK_EN.
module overlay_frame_scheduler #(
  parameter int FRAME_LINE   = 480,
  parameter int BLINK_FRAMES = 30,
  parameter int NUM_LAYERS   = 6
) (
  input  logic                  clock25MHz,
  input  logic                  reset,
  input  logic [9:0]            xOrd,
  input  logic [9:0]            yOrd,
  input  logic                  cfgValid,
  output logic                  cfgReady,
  input  logic [2:0]            cfgAddr,
  input  logic [7:0]            cfgData,
  output logic [NUM_LAYERS-1:0] layerMask,
  output logic [7:0]            bgR,
  output logic [7:0]            bgG,
  output logic [7:0]            bgB,
  output logic                  frameStart,
  output logic [7:0]            frameCount,
  output logic                  blinkPhase,
  output logic                  commitPending
`ifdef OVERLAY_CFG_READBACK_EN
  ,
  output logic [7:0]            cfgRdata
`endif
);

  typedef enum logic [1:0] {IDLE, ARMED, COMMIT} stateT;

  stateT                 state;
  stateT                 nextState;
  logic                  boundary;
  logic                  boundaryReg;
  logic                  cfgXfer;
  logic [7:0]            blinkCnt;
  logic [NUM_LAYERS-1:0] shadowEnable;
  logic [NUM_LAYERS-1:0] shadowBlink;
  logic [7:0]            shadowR;
  logic [7:0]            shadowG;
  logic [7:0]            shadowB;
  logic [NUM_LAYERS-1:0] activeEnable;
  logic [NUM_LAYERS-1:0] activeBlink;

  assign boundary = (xOrd == 10'd0) && (yOrd == 10'(FRAME_LINE));
  assign cfgXfer  = cfgValid && cfgReady;

  always_ff @(posedge clock25MHz) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState     = state;
    cfgReady      = 1'b0;
    commitPending = 1'b0;
    case (state)
      IDLE: begin
        cfgReady = 1'b1;
        if (cfgValid && (cfgAddr == 3'd5)) begin
          nextState = ARMED;
        end
      end
      ARMED: begin
        commitPending = 1'b1;
        if (frameStart) begin
          nextState = COMMIT;
        end
      end
      COMMIT: begin
        commitPending = 1'b1;
        nextState     = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // One pulse per rising edge of the boundary condition, however long it is held.
  always_ff @(posedge clock25MHz) begin
    if (reset) begin
      boundaryReg <= 1'b0;
      frameStart  <= 1'b0;
      frameCount  <= 8'd0;
      blinkCnt    <= 8'd0;
      blinkPhase  <= 1'b1;
    end else begin
      boundaryReg <= boundary;
      frameStart  <= boundary && !boundaryReg;
      if (frameStart) begin
        frameCount <= frameCount + 8'd1;
        if (blinkCnt == 8'(BLINK_FRAMES - 1)) begin
          blinkCnt   <= 8'd0;
          blinkPhase <= ~blinkPhase;
        end else begin
          blinkCnt <= blinkCnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clock25MHz) begin
    if (reset) begin
      shadowEnable <= '1;
      shadowBlink  <= '0;
      shadowR      <= 8'h00;
      shadowG      <= 8'h20;
      shadowB      <= 8'h40;
    end else if (cfgXfer) begin
      case (cfgAddr)
        3'd0:    shadowEnable <= cfgData[NUM_LAYERS-1:0];
        3'd1:    shadowBlink  <= cfgData[NUM_LAYERS-1:0];
        3'd2:    shadowR      <= cfgData;
        3'd3:    shadowG      <= cfgData;
        3'd4:    shadowB      <= cfgData;
        default: ;
      endcase
    end
  end

  // Whole shadow set moves to the active set in the single COMMIT cycle.
  always_ff @(posedge clock25MHz) begin
    if (reset) begin
      activeEnable <= '1;
      activeBlink  <= '0;
      bgR          <= 8'h00;
      bgG          <= 8'h20;
      bgB          <= 8'h40;
    end else if (state == COMMIT) begin
      activeEnable <= shadowEnable;
      activeBlink  <= shadowBlink;
      bgR          <= shadowR;
      bgG          <= shadowG;
      bgB          <= shadowB;
    end
  end

  assign layerMask = activeEnable & ~(activeBlink & {NUM_LAYERS{~blinkPhase}});

`ifdef OVERLAY_CFG_READBACK_EN
  always_comb begin
    cfgRdata = 8'h00;
    case (cfgAddr)
      3'd0:    cfgRdata = 8'(shadowEnable);
      3'd1:    cfgRdata = 8'(shadowBlink);
      3'd2:    cfgRdata = shadowR;
      3'd3:    cfgRdata = shadowG;
      3'd4:    cfgRdata = shadowB;
      default: cfgRdata = 8'h00;
    endcase
  end
`endif

endmodule

// File: tb/tb_overlay_frame_scheduler.sv
// tb/tb_overlay_frame_scheduler.sv - self-checking bench for overlay_frame_scheduler
// Reference model tracks shadow/active sets, commit timing and frame counters by cycle timestamps.
module tb_overlay_frame_scheduler;

  localparam int FRAME_LINE = 480;
  localparam int BLINK      = 2;
  localparam int NL         = 6;

  logic          clock25MHz = 1'b0;
  logic          reset;
  logic [9:0]    xOrd;
  logic [9:0]    yOrd;
  logic          cfgValid;
  logic          cfgReady;
  logic [2:0]    cfgAddr;
  logic [7:0]    cfgData;
  logic [NL-1:0] layerMask;
  logic [7:0]    bgR;
  logic [7:0]    bgG;
  logic [7:0]    bgB;
  logic          frameStart;
  logic [7:0]    frameCount;
  logic          blinkPhase;
  logic          commitPending;
`ifdef OVERLAY_CFG_READBACK_EN
  logic [7:0]    cfgRdata;
`endif

  always #20 clock25MHz = ~clock25MHz;

  overlay_frame_scheduler #(
    .FRAME_LINE(FRAME_LINE),
    .BLINK_FRAMES(BLINK),
    .NUM_LAYERS(NL)
  ) dut (
    .clock25MHz(clock25MHz),
    .reset(reset),
    .xOrd(xOrd),
    .yOrd(yOrd),
    .cfgValid(cfgValid),
    .cfgReady(cfgReady),
    .cfgAddr(cfgAddr),
    .cfgData(cfgData),
    .layerMask(layerMask),
    .bgR(bgR),
    .bgG(bgG),
    .bgB(bgB),
    .frameStart(frameStart),
    .frameCount(frameCount),
    .blinkPhase(blinkPhase),
    .commitPending(commitPending)
`ifdef OVERLAY_CFG_READBACK_EN
    ,
    .cfgRdata(cfgRdata)
`endif
  );

  int nAsserts = 0;
  int nFail    = 0;

  // reference model state
  int       cyc = 0;
  int       applyAt = -1;
  int       mCount = 0;
  int       mBlink = 0;
  int       fsSeen = 0;
  int       lastFsCyc = 0;
  int       xferCyc = 0;
  bit       mFs, prevC, armed, mReady, mPhase, xferd;
  bit [5:0] sEn, sBl, aEn, aBl;
  bit [7:0] sR, sG, sB, aR, aG, aB;

  // coordinate generator: random off-boundary pixels, then 1..3 cycles parked on the boundary
  int gPos = 0;
  int gLen = 16;
  int gHold = 2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [5:0] expMask();
    return aEn & ~(aBl & {6{~mPhase}});
  endfunction

  task automatic offBoundary();
    case ($urandom_range(0, 3))
      0: begin xOrd = 10'd0; yOrd = 10'($urandom_range(0, FRAME_LINE - 1)); end
      1: begin xOrd = 10'($urandom_range(1, 799)); yOrd = 10'(FRAME_LINE); end
      default: begin xOrd = 10'($urandom_range(1, 799)); yOrd = 10'($urandom_range(0, 524)); end
    endcase
  endtask

  task automatic genCoord();
    if (gPos >= gLen - gHold) begin
      xOrd = 10'd0;
      yOrd = 10'(FRAME_LINE);
    end else begin
      offBoundary();
    end
    gPos++;
    if (gPos == gLen) begin
      gPos  = 0;
      gLen  = $urandom_range(12, 20);
      gHold = $urandom_range(1, 3);
    end
  endtask

  task automatic modelEdge();
    bit c, newFs, fsBefore, armedBefore;
    cyc++;
    xferd = 0;
    if (reset) begin
      sEn = '1; aEn = '1; sBl = '0; aBl = '0;
      sR = 8'h00; sG = 8'h20; sB = 8'h40;
      aR = 8'h00; aG = 8'h20; aB = 8'h40;
      mFs = 0; prevC = 0; armed = 0; applyAt = -1;
      mCount = 0; mBlink = 0; mPhase = 1; mReady = 1;
      return;
    end
    c           = (xOrd == 10'd0) && (yOrd == 10'(FRAME_LINE));
    newFs       = c && !prevC;
    prevC       = c;
    fsBefore    = mFs;
    armedBefore = armed;
    if (applyAt == cyc) begin
      aEn = sEn; aBl = sBl; aR = sR; aG = sG; aB = sB;
      applyAt = -1;
    end
    if (armedBefore && fsBefore) begin
      armed   = 0;
      applyAt = cyc + 1;
    end
    if (cfgValid && mReady) begin
      xferd   = 1;
      xferCyc = cyc;
      case (cfgAddr)
        3'd0: sEn = cfgData[5:0];
        3'd1: sBl = cfgData[5:0];
        3'd2: sR = cfgData;
        3'd3: sG = cfgData;
        3'd4: sB = cfgData;
        3'd5: armed = 1;
        default: ;
      endcase
    end
    if (fsBefore) begin
      mCount = (mCount + 1) % 256;
      if (mBlink == BLINK - 1) begin
        mBlink = 0;
        mPhase = !mPhase;
      end else begin
        mBlink++;
      end
    end
    mFs = newFs;
    if (newFs) begin
      fsSeen++;
      lastFsCyc = cyc;
    end
    mReady = !armed && (applyAt < 0);
  endtask

  task automatic compareAll();
    check("frameStart", 32'(frameStart), 32'(mFs));
    check("frameCount", 32'(frameCount), 32'(mCount));
    check("blinkPhase", 32'(blinkPhase), 32'(mPhase));
    check("cfgReady", 32'(cfgReady), 32'(mReady));
    check("commitPending", 32'(commitPending), 32'(!mReady));
    check("layerMask", 32'(layerMask), 32'(expMask()));
    check("bgR", 32'(bgR), 32'(aR));
    check("bgG", 32'(bgG), 32'(aG));
    check("bgB", 32'(bgB), 32'(aB));
`ifdef OVERLAY_CFG_READBACK_EN
    begin
      bit [7:0] expRd;
      case (cfgAddr)
        3'd0: expRd = 8'(sEn);
        3'd1: expRd = 8'(sBl);
        3'd2: expRd = sR;
        3'd3: expRd = sG;
        3'd4: expRd = sB;
        default: expRd = 8'h00;
      endcase
      check("cfgRdata", 32'(cfgRdata), 32'(expRd));
    end
`endif
  endtask

  task automatic tick();
    if (reset) offBoundary();
    else genCoord();
    @(posedge clock25MHz);
    #1;
    modelEdge();
    compareAll();
  endtask

  task automatic runFrames(input int n);
    int target = fsSeen + n;
    int budget = n * 40 + 40;
    while (fsSeen < target && budget > 0) begin
      tick();
      budget--;
    end
    if (fsSeen < target) begin
      nAsserts++;
      nFail++;
      $error("FAIL runFrames_timeout observed=%0d expected=%0d", fsSeen, target);
    end
  endtask

  task automatic write(input logic [2:0] addr, input logic [7:0] data);
    int n = 0;
    cfgValid = 1'b1;
    cfgAddr  = addr;
    cfgData  = data;
    tick();
    n++;
    while (!xferd && n < 200) begin
      tick();
      n++;
    end
    cfgValid = 1'b0;
    if (!xferd) begin
      nAsserts++;
      nFail++;
      $error("FAIL write_timeout addr=%0d observed=no transfer expected=transfer", addr);
    end
  endtask

  initial begin
    int startCnt;
    int budget;
    reset    = 1'b1;
    cfgValid = 1'b0;
    cfgAddr  = 3'd0;
    cfgData  = 8'd0;
    xOrd     = 10'd1;
    yOrd     = 10'd0;

    // reset state
    repeat (3) tick();
    check("rst_mask", 32'(layerMask), 32'h3F);
    check("rst_bg", {8'h0, bgR, bgG, bgB}, 32'h00_2040);
    check("rst_count", 32'(frameCount), 32'h0);
    check("rst_phase", 32'(blinkPhase), 32'h1);
    check("rst_ready", 32'(cfgReady), 32'h1);
    reset = 1'b0;

    // two idle frames
    runFrames(2);
    tick();
    check("idle_count", 32'(frameCount), 32'd2);
    check("idle_mask", 32'(layerMask), 32'h3F);

    // shadow writes stay invisible until a commit lands two cycles after frameStart
    write(3'd2, 8'hFF);
    write(3'd0, 8'h05);
    runFrames(1);
    repeat (3) tick();
    check("noCommit_bgR", 32'(bgR), 32'h00);
    check("noCommit_mask", 32'(layerMask), 32'h3F);
    write(3'd5, 8'hA5);
    check("armed_pending", 32'(commitPending), 32'h1);
    check("armed_ready", 32'(cfgReady), 32'h0);
    runFrames(1);
    check("commit_fs_bgR", 32'(bgR), 32'h00);
    tick();
    check("commit_n2_bgR", 32'(bgR), 32'h00);
    tick();
    check("commit_n3_bgR", 32'(bgR), 32'hFF);
    check("commit_n3_mask", 32'(layerMask), 32'h05);
    check("commit_n3_ready", 32'(cfgReady), 32'h1);

    // arm in the same cycle as frameStart: waits for the next boundary
    write(3'd4, 8'h77);
    budget = 60;
    while (!mFs && budget > 0) begin
      tick();
      budget--;
    end
    check("sameCycle_fs", 32'(frameStart), 32'h1);
    cfgValid = 1'b1;
    cfgAddr  = 3'd5;
    tick();
    cfgValid = 1'b0;
    check("sameCycle_xfer", 32'(xferd), 32'h1);
    repeat (3) tick();
    check("sameCycle_pending", 32'(commitPending), 32'h1);
    check("sameCycle_bgB", 32'(bgB), 32'h40);
    runFrames(1);
    repeat (2) tick();
    check("nextFrame_bgB", 32'(bgB), 32'h77);

    // blinking layers
    write(3'd0, 8'h3F);
    write(3'd1, 8'h08);
    write(3'd5, 8'h00);
    for (int f = 0; f < 8; f++) begin
      runFrames(1);
      repeat (3) tick();
      check("blink_mask", 32'(layerMask), mPhase ? 32'h3F : 32'h37);
    end

    // arm request held while ARMED is accepted in the first IDLE cycle
    write(3'd5, 8'h00);
    cfgValid = 1'b1;
    cfgAddr  = 3'd5;
    budget   = 200;
    tick();
    while (!xferd && budget > 0) begin
      tick();
      budget--;
    end
    cfgValid = 1'b0;
    check("hold_latency", 32'(xferCyc - lastFsCyc), 32'd3);

    // reset mid-ARMED drops the commit and restores the shadow set
    check("preRst_pending", 32'(commitPending), 32'h1);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("midRst_pending", 32'(commitPending), 32'h0);
    check("midRst_ready", 32'(cfgReady), 32'h1);
    runFrames(1);
    repeat (3) tick();
    check("midRst_noCommit", 32'(commitPending), 32'h0);
    write(3'd5, 8'h00);
    runFrames(1);
    repeat (2) tick();
    check("midRst_shadowR", 32'(bgR), 32'h00);
    check("midRst_shadowMask", 32'(layerMask), 32'h3F);

    // reserved addresses change nothing
    write(3'd6, 8'($urandom));
    write(3'd7, 8'($urandom));
    write(3'd5, 8'h00);
    runFrames(1);
    repeat (2) tick();
    check("reserved_bg", {8'h0, bgR, bgG, bgB}, 32'h00_2040);
    check("reserved_mask", 32'(layerMask), 32'h3F);

    // random configuration traffic
    for (int i = 0; i < 400; i++) begin
      cfgValid = 1'($urandom_range(0, 1));
      cfgAddr  = 3'($urandom_range(0, 7));
      cfgData  = 8'($urandom);
      tick();
    end
    cfgValid = 1'b0;

    // frame counter wraps after 256 frames
    startCnt = mCount;
    runFrames(256);
    tick();
    check("wrap_count", 32'(frameCount), 32'(startCnt));

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/overlay_frame_scheduler.md
Name: overlay_frame_scheduler

Overview:
Frame-synchronous configuration controller for the layer compositing stage of the VGA scope display. It accepts register writes from the UI/menu logic through a valid/ready handshake and holds them in shadow registers. The shadow set is committed atomically at the frame boundary, so the compositor never shows a half-updated configuration mid-frame. It drives the per-layer enable mask (with per-layer blinking) and the background colour consumed by the compositor.

Parameters:
FRAME_LINE, 480, yOrd value of the first non-visible line; frame boundary = xOrd==0 && yOrd==FRAME_LINE
BLINK_FRAMES, 30, frames per blink half-period (legal 1..255)
NUM_LAYERS, 6, layer count; bit order text,ui,cursor,trig,wave,axis = bit 5..0

Ports:
clock25MHz  input  1  pixel clock; the only clock
reset  input  1  synchronous, active-high reset
xOrd  input  10  current pixel column from the VGA timing generator
yOrd  input  10  current pixel row
cfgValid  input  1  write request
cfgReady  output  1  scheduler can accept a write
cfgAddr  input  3  0=enable mask, 1=blink mask, 2=bgR, 3=bgG, 4=bgB, 5=commit, 6/7=reserved
cfgData  input  8  write data; enable and blink masks use bits [NUM_LAYERS-1:0]
layerMask  output  NUM_LAYERS  effective per-layer enable for the compositor
bgR, bgG, bgB  output  8 each  active background colour
frameStart  output  1  one-cycle pulse per frame boundary
frameCount  output  8  frame counter
blinkPhase  output  1  current blink phase
commitPending  output  1  high while a commit is armed and not yet applied

Behaviour:
- Reset: synchronous, active-high, clock25MHz only. Takes priority over all other activity, including mid-ARMED or mid-COMMIT, and drops any armed commit.
  - Shadow and active enable = all ones; blink = 0; bg = 00/20/40 hex.
  - frameStart=0, frameCount=0, blink counter=0, blinkPhase=1, state=IDLE, cfgReady=1, commitPending=0.
- Boundary detect: condition C = (xOrd==0 && yOrd==FRAME_LINE), edge-detected against its registered value. C first true in cycle N -> frameStart=1 in cycle N+1 only. A C held true for several cycles still gives exactly one pulse.
- Handshake: a write transfers on a clock edge where cfgValid && cfgReady. cfgData and cfgAddr are sampled only then.
  - Addr 0..4 write the shadow register.
  - Addr 5 arms a commit; its data is ignored.
  - Addr 6/7 are accepted and discarded.
  - A write without ready is held by the requester, not dropped by this block.
- FSM:
  - IDLE: cfgReady=1. A transferred addr-5 write -> ARMED.
  - ARMED: cfgReady=0, commitPending=1. frameStart=1 -> COMMIT. A frameStart in the same cycle the arm transfers does not count; the commit waits for the next boundary.
  - COMMIT (one cycle): cfgReady=0, commitPending=1. Shadow is copied to active at the end of this cycle -> IDLE.
  - Cycle-level latency: frameStart in cycle N+1 -> COMMIT in N+2 -> new bg/mask visible and cfgReady=1 in N+3.
- Frame/blink counters: on each frameStart cycle, frameCount increments (255 wraps to 0). The blink counter increments; when it equals BLINK_FRAMES-1 it resets to 0 and blinkPhase toggles. Both updates are visible the cycle after frameStart.
- Mask formula: layerMask = activeEnable & ~(activeBlink & {NUM_LAYERS{~blinkPhase}}). It is a function of registers only, so it is glitch-free.
- bgR/G/B drive the active registers directly. Shadow writes never change the outputs before a commit.
- Shadow registers retain their values after a commit; partial reprogramming is allowed.

Optional Feature:
- Macro: OVERLAY_CFG_READBACK_EN.
- Defined: adds output cfgRdata (8 bits). It is combinational, equals the shadow register selected by cfgAddr (masks zero-extended), and reads 00 for addresses 5..7.
- Undefined: the port and its mux are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle 2 frames -> layerMask=3F, bg=00/20/40, frameCount=2, exactly one frameStart per frame, cfgReady=1 throughout.
- Write bgR=FF, enable=05, no commit, run 1 frame -> outputs unchanged. Then write addr5 -> commitPending=1, cfgReady=0 until boundary; bgR=FF and layerMask=05 appear exactly 2 cycles after frameStart.
- Arm commit on the same cycle as frameStart -> no commit at that boundary; commit occurs at the following boundary.
- BLINK_FRAMES=2, enable=3F, blink=08 committed -> blinkPhase toggles every 2 frames; layerMask alternates 3F / 37.
- Hold cfgValid with addr5 while ARMED -> not accepted until the cycle after COMMIT. Assert reset mid-ARMED -> commitPending=0, shadow reset, and no commit at the next boundary.
- frameCount wrap: run 256 frames -> frameCount returns to 00. Addr 6/7 writes -> no state change.
